instr_fetch_stage: RTL and testbench

- Fetch stage directly upstream of Extend.
- Holds the PC, issues single-outstanding reads to instruction memory with a req/gnt/valid handshake, and latches the returned word into the instruction register.
- Presents Instr and its field slices to decode: ImmShort = Instr[31:20] drives Extend; Rs1, Rs2 and Rd drive the register file.
- Accepts redirects (branch/jump) from execute and flushes in-flight fetches.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/instr_fetch_pc_register.sv | 32 +++
 rtl/instr_fetch_stage.sv | 114 +++++++++++
 tb/tb_instr_fetch_stage.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int IMM_HI = 31;
    localparam int IMM_LO = 20;
    localparam int RS1_HI = 19;
    localparam int RS1_LO = 15;
    localparam int RS2_HI = 24;
    localparam int RS2_LO = 20;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 7;

endpackage

// File: rtl/instr_fetch_pc_register.sv
// Program counter: loads either PC+4 or a word-aligned redirect target.
module pc_register
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic        i_sel_target,
    input  logic [31:0] i_target,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4
);

    logic [31:0] r_pc;
    logic [31:0] w_next;

    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc + 32'd4;
    // Redirect targets are forced onto a word boundary.
    assign w_next     = i_sel_target ? (i_target & ~32'd3) : o_pc_plus4;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= w_next;
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: single-outstanding instruction memory reads, instruction
// register with valid/ready hand-off to decode, and redirect flush.
module instr_fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemGnt,
    input  logic        IMemValid,
    input  logic [31:0] IMemRData,
    input  logic        PCRedirect,
    input  logic [31:0] PCTarget,
    input  logic        InstrReady,
    output logic        InstrValid,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic [11:0] ImmShort,
    output logic [4:0]  Rs1,
    output logic [4:0]  Rs2,
    output logic [4:0]  Rd,
    output logic [1:0]  o_dbg_state
);

    fetch_state_t r_state;
    logic         r_discard;
    logic [31:0]  r_instr;
    logic         r_instr_valid;
    logic [31:0]  w_pc;
    logic [31:0]  w_pc_plus4;
    logic         w_pc_load;

    always_comb begin
        w_pc_load = 1'b0;
        case (r_state)
            S_REQ, S_WAIT: w_pc_load = PCRedirect;
            S_HOLD:        w_pc_load = PCRedirect | InstrReady;
            default:       w_pc_load = 1'b0;
        endcase
    end

    pc_register #(.RESET_PC(RESET_PC)) u_pc (
        .i_clk        (CLK),
        .i_rst_n      (RST_N),
        .i_load       (w_pc_load),
        .i_sel_target (PCRedirect),
        .i_target     (PCTarget),
        .o_pc         (w_pc),
        .o_pc_plus4   (w_pc_plus4)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state       <= S_IDLE;
            r_discard     <= 1'b0;
            r_instr       <= NOP_INSTR;
            r_instr_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_REQ;
                S_REQ: begin
                    // A grant together with a redirect fetches the stale address.
                    if (IMemGnt) begin
                        r_state <= S_WAIT;
                        if (PCRedirect) r_discard <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (IMemValid) begin
                        if (r_discard || PCRedirect) begin
                            r_discard <= 1'b0;
                            r_state   <= S_REQ;
                        end else begin
                            r_instr       <= IMemRData;
                            r_instr_valid <= 1'b1;
                            r_state       <= S_HOLD;
                        end
                    end else if (PCRedirect) begin
                        r_discard <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (PCRedirect) begin
                        r_instr_valid <= 1'b0;
                        r_instr       <= NOP_INSTR;
                        r_state       <= S_REQ;
                    end else if (InstrReady) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= S_REQ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign IMemReq     = (r_state == S_REQ);
    assign IMemAddr    = w_pc;
    assign PC          = w_pc;
    assign PCPlus4     = w_pc_plus4;
    assign Instr       = r_instr;
    assign InstrValid  = r_instr_valid;
    assign ImmShort    = r_instr[IMM_HI:IMM_LO];
    assign Rs1         = r_instr[RS1_HI:RS1_LO];
    assign Rs2         = r_instr[RS2_HI:RS2_LO];
    assign Rd          = r_instr[RD_HI:RD_LO];
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage with a memory responder and a
// rule-level model checked every cycle.
module tb_instr_fetch_stage;
  import fetch_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemGnt;
  logic        IMemValid;
  logic [31:0] IMemRData;
  logic        PCRedirect;
  logic [31:0] PCTarget;
  logic        InstrReady;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [11:0] ImmShort;
  logic [4:0]  Rs1;
  logic [4:0]  Rs2;
  logic [4:0]  Rd;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int gnt_allow = 1;
  int resp_delay = 1;
  logic [31:0] exp_q[$];

  instr_fetch_stage dut (
    .CLK(CLK), .RST_N(RST_N),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemGnt(IMemGnt),
    .IMemValid(IMemValid), .IMemRData(IMemRData),
    .PCRedirect(PCRedirect), .PCTarget(PCTarget), .InstrReady(InstrReady),
    .InstrValid(InstrValid), .Instr(Instr), .PC(PC), .PCPlus4(PCPlus4),
    .ImmShort(ImmShort), .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd),
    .o_dbg_state(dbg_state)
  );

  // clock / reset-relative cycle counter
  always #5 CLK = ~CLK;

  initial begin
    forever begin
      @(posedge CLK);
      cyc = RST_N ? cyc + 1 : 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_valid(input int max, input string nm);
    int n = 0;
    step();
    while (!InstrValid && n < max) begin
      step();
      n++;
    end
    chk(nm, {31'b0, InstrValid}, 32'd1);
  endtask

  // memory responder: grant in the request cycle, data resp_delay cycles later
  initial begin
    int pend_cnt = 0;
    logic [31:0] pend_addr = 32'h0;
    IMemGnt = 1'b0;
    IMemValid = 1'b0;
    IMemRData = 32'h0;
    forever begin
      @(negedge CLK);
      IMemValid = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          IMemValid = 1'b1;
          IMemRData = mem_word(pend_addr);
        end
      end
      IMemGnt = IMemReq && (gnt_allow != 0) && (pend_cnt == 0);
      if (IMemGnt) begin
        pend_cnt = resp_delay;
        pend_addr = IMemAddr;
      end
    end
  end

  // scoreboard: rule-level model checked after every active edge
  initial begin
    logic prev_rst = 1'b0;
    logic prev_valid = 1'b0;
    logic prev_req = 1'b0;
    logic [31:0] prev_pc = 32'h0;
    logic [31:0] prev_instr = 32'h0;
    logic [31:0] prev_addr = 32'h0;
    logic [31:0] e;
    forever begin
      step();
      if (RST_N && prev_rst) begin
        chk("pcplus4", PCPlus4, PC + 32'd4);
        chk("imemaddr_eq_pc", IMemAddr, PC);
        chk("immshort", {20'b0, ImmShort}, Instr >> 20);
        chk("rs1", {27'b0, Rs1}, (Instr >> 15) & 32'h1f);
        chk("rs2", {27'b0, Rs2}, (Instr >> 20) & 32'h1f);
        chk("rd", {27'b0, Rd}, (Instr >> 7) & 32'h1f);
        if (InstrValid) begin
          chk("instr_word", Instr, mem_word(PC));
          chk("no_req_in_hold", {31'b0, IMemReq}, 32'd0);
        end
        if (InstrValid && !prev_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_instr_pc", PC, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("present_pc", PC, e);
          end
        end
        if (prev_valid && PCRedirect) begin
          chk("flush_valid", {31'b0, InstrValid}, 32'd0);
          chk("flush_nop", Instr, NOP_INSTR);
        end else if (prev_valid && InstrReady) begin
          chk("consume_valid", {31'b0, InstrValid}, 32'd0);
          chk("consume_pc", PC, prev_pc + 32'd4);
        end else if (prev_valid) begin
          chk("stall_valid", {31'b0, InstrValid}, 32'd1);
          chk("stall_pc", PC, prev_pc);
          chk("stall_instr", Instr, prev_instr);
        end
        if (PCRedirect) chk("redirect_pc", PC, PCTarget & ~32'd3);
        if (prev_req && !IMemGnt && !PCRedirect && IMemReq)
          chk("addr_stable", IMemAddr, prev_addr);
      end
      prev_rst = RST_N;
      prev_valid = InstrValid;
      prev_pc = PC;
      prev_instr = Instr;
      prev_req = IMemReq;
      prev_addr = IMemAddr;
    end
  end

  // driver
  initial begin
    int t4;
    int t8;
    int n;
    RST_N = 1'b0;
    PCRedirect = 1'b0;
    PCTarget = 32'h0;
    InstrReady = 1'b0;
    repeat (3) step();
    chk("rst_req", {31'b0, IMemReq}, 32'd0);
    chk("rst_addr", IMemAddr, 32'h0);
    chk("rst_pc", PC, 32'h0);
    chk("rst_instr", Instr, 32'h0000_0013);
    chk("rst_valid", {31'b0, InstrValid}, 32'd0);
    chk("rst_state", {30'b0, dbg_state}, {30'b0, S_IDLE});

    // first fetch, zero-wait memory
    exp_q.push_back(32'h0);
    @(negedge CLK) RST_N = 1'b1;
    step();
    chk("cyc1_num", cyc, 1);
    chk("cyc1_req", {31'b0, IMemReq}, 32'd1);
    chk("cyc1_addr", IMemAddr, 32'h0);
    step();
    chk("cyc2_valid", {31'b0, InstrValid}, 32'd0);
    step();
    chk("cyc3_valid", {31'b0, InstrValid}, 32'd1);
    chk("cyc3_instr", Instr, 32'h0050_0093);
    chk("cyc3_imm", {20'b0, ImmShort}, 32'h005);
    chk("cyc3_rd", {27'b0, Rd}, 32'd1);
    chk("cyc3_pc", PC, 32'h0);
    chk("cyc3_pcplus4", PCPlus4, 32'h4);

    // decode stalled for 5 cycles
    repeat (5) begin
      step();
      chk("hold_valid", {31'b0, InstrValid}, 32'd1);
      chk("hold_pc", PC, 32'h0);
      chk("hold_req", {31'b0, IMemReq}, 32'd0);
    end

    // back-to-back sequential fetches
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    @(negedge CLK) InstrReady = 1'b1;
    wait_valid(10, "seq4_arrive");
    t4 = cyc;
    chk("seq4_pc", PC, 32'h4);
    wait_valid(10, "seq8_arrive");
    t8 = cyc;
    chk("seq8_pc", PC, 32'h8);
    chk("seq_spacing", t8 - t4, 32'd3);
    @(negedge CLK) InstrReady = 1'b0;

    // redirect while waiting for a slow response
    resp_delay = 3;
    @(negedge CLK) InstrReady = 1'b1;
    @(negedge CLK) InstrReady = 1'b0;
    step();
    chk("wait_state", {30'b0, dbg_state}, {30'b0, S_WAIT});
    @(negedge CLK) begin PCRedirect = 1'b1; PCTarget = 32'h0000_0102; end
    @(negedge CLK) PCRedirect = 1'b0;
    exp_q.push_back(32'h100);
    n = 0;
    step();
    while (!IMemReq && n < 10) begin
      step();
      n++;
    end
    chk("redir_req", {31'b0, IMemReq}, 32'd1);
    chk("redir_addr", IMemAddr, 32'h100);
    wait_valid(20, "redir_arrive");
    chk("redir_pc", PC, 32'h100);

    // redirect and ready together in hold
    @(negedge CLK) begin PCRedirect = 1'b1; InstrReady = 1'b1; PCTarget = 32'h40; end
    step();
    chk("rr_valid", {31'b0, InstrValid}, 32'd0);
    chk("rr_instr", Instr, 32'h0000_0013);
    chk("rr_req", {31'b0, IMemReq}, 32'd1);
    chk("rr_addr", IMemAddr, 32'h40);
    @(negedge CLK) begin PCRedirect = 1'b0; InstrReady = 1'b0; end
    exp_q.push_back(32'h40);
    wait_valid(20, "rr_arrive");
    chk("rr_pc", PC, 32'h40);

    // redirect while a request is waiting for grant
    gnt_allow = 0;
    @(negedge CLK) InstrReady = 1'b1;
    @(negedge CLK) InstrReady = 1'b0;
    repeat (3) step();
    chk("nognt_req", {31'b0, IMemReq}, 32'd1);
    chk("nognt_addr", IMemAddr, 32'h44);
    @(negedge CLK) begin PCRedirect = 1'b1; PCTarget = 32'h83; end
    @(negedge CLK) begin PCRedirect = 1'b0; gnt_allow = 1; end
    exp_q.push_back(32'h80);
    wait_valid(20, "nognt_arrive");
    chk("nognt_pc", PC, 32'h80);

    // reset while a response is outstanding
    @(negedge CLK) InstrReady = 1'b1;
    @(negedge CLK) InstrReady = 1'b0;
    step();
    @(negedge CLK) RST_N = 1'b0;
    step();
    chk("mrst_pc", PC, 32'h0);
    chk("mrst_valid", {31'b0, InstrValid}, 32'd0);
    chk("mrst_req", {31'b0, IMemReq}, 32'd0);
    repeat (3) step();
    chk("mrst_pc_late", PC, 32'h0);
    chk("mrst_valid_late", {31'b0, InstrValid}, 32'd0);
    chk("mrst_instr_late", Instr, 32'h0000_0013);
    exp_q.push_back(32'h0);
    resp_delay = 1;
    @(negedge CLK) RST_N = 1'b1;
    wait_valid(10, "mrst_arrive");
    chk("mrst_restart_pc", PC, 32'h0);
    chk("mrst_restart_instr", Instr, 32'h0050_0093);

    repeat (2) step();
    chk("exp_q_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
